// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad port: button bit positions,
// shift-register fill value and the start-button polarity mask.
package nes_joypad_pkg;

   // Button positions inside every 8-bit pad vector
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // Value shifted in behind the eight buttons: reads 9+ return 1
   localparam logic SH_FILL = 1'b1;

   // The onboard start button is wired active-low
   localparam logic [7:0] START_INV_MASK = 8'h08;

endpackage

// File: rtl/button_debounce.sv
// One onboard button: 2-flop synchronizer followed by a stability counter.
// The accepted level only follows the synchronized sample after it has
// disagreed with the accepted level for C_debounce_cycles consecutive cycles.
module button_debounce #(
   parameter int   C_debounce_cycles = 250000,
   parameter logic C_reset_level     = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw_i,
   output logic level_o
);

   localparam int CNT_W = (C_debounce_cycles > 1) ? $clog2(C_debounce_cycles) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_debounce_cycles - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count cycles of disagreement; any agreeing sample restarts the count
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchronizer, counter and accepted level; reset to the released level
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1_q <= C_reset_level;
         sync2_q <= C_reset_level;
         level_q <= C_reset_level;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/nes_joypad_port.sv
// NES controller port: merges debounced onboard buttons with a USB pad,
// serializes the result on the $4016 strobe/clock protocol, or passes an
// external NES pad straight through when C_use_external is set.
module nes_joypad_port
   import nes_joypad_pkg::*;
#(
   parameter int   C_debounce_cycles = 250000,
   parameter logic C_use_external    = 1'b0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] btn_raw,
   input  logic [7:0] usb_buttons,
   input  logic       joy_strobe,
   input  logic       joy_clock,
   input  logic       ext_joy_data,
   output logic       joy_bit,
   output logic [7:0] pad_state
);

   logic [7:0] deb_lvl;
   logic [7:0] usb_s1_q, usb_s2_q, usb_prev_q;
   logic [7:0] usb_acc_q, usb_acc_d;
   logic [7:0] pad_q, pad_d;
   logic [7:0] sh_q, sh_d;
   logic       last_clk_q;
   logic       joy_fall;
   logic       ext_s1_q, ext_s2_q;

   // Per-button debounce; start idles high because its switch is active-low
   for (genvar gi = 0; gi < 8; gi++) begin : g_btn
      button_debounce #(
         .C_debounce_cycles (C_debounce_cycles),
         .C_reset_level     ((gi == BTN_START) ? 1'b1 : 1'b0)
      ) u_deb (
         .clock   (clock),
         .reset_n (reset_n),
         .raw_i   (btn_raw[gi]),
         .level_o (deb_lvl[gi])
      );
   end

   // joy_strobe/joy_clock come from this clock domain, so no synchronizer
   assign joy_fall = !joy_clock && last_clk_q;

   // Next-state for USB acceptance, merged pad vector and shift register
   always_comb begin
      usb_acc_d = usb_acc_q;
      if (usb_s2_q == usb_prev_q) begin
         usb_acc_d = usb_s2_q;
      end

      pad_d = (deb_lvl ^ START_INV_MASK) | usb_acc_q;

      sh_d = sh_q;
      if (joy_strobe) begin
         sh_d = pad_q;
      end else if (joy_fall) begin
         sh_d = {SH_FILL, sh_q[7:1]};
      end
   end

   // All state registers; the external-pad synchronizer idles released (1)
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         usb_s1_q   <= '0;
         usb_s2_q   <= '0;
         usb_prev_q <= '0;
         usb_acc_q  <= '0;
         pad_q      <= '0;
         sh_q       <= '0;
         last_clk_q <= 1'b0;
         ext_s1_q   <= 1'b1;
         ext_s2_q   <= 1'b1;
      end else begin
         usb_s1_q   <= usb_buttons;
         usb_s2_q   <= usb_s1_q;
         usb_prev_q <= usb_s2_q;
         usb_acc_q  <= usb_acc_d;
         pad_q      <= pad_d;
         sh_q       <= sh_d;
         last_clk_q <= joy_clock;
         ext_s1_q   <= ext_joy_data;
         ext_s2_q   <= ext_s1_q;
      end
   end

   assign pad_state = pad_q;
   assign joy_bit   = C_use_external ? !ext_s2_q : sh_q[0];

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port with a short debounce window.
// A second instance runs in external-pad mode for the pass-through path.
module tb_nes_joypad_port;

   localparam int DEB = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] btn_raw;
   logic [7:0] usb_buttons;
   logic       joy_strobe;
   logic       joy_clock;
   logic       ext_joy_data;
   logic       joy_bit, joy_bit_x;
   logic [7:0] pad_state, pad_state_x;

   int total = 0;
   int bad   = 0;

   nes_joypad_port #(.C_debounce_cycles(DEB), .C_use_external(1'b0)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .btn_raw      (btn_raw),
      .usb_buttons  (usb_buttons),
      .joy_strobe   (joy_strobe),
      .joy_clock    (joy_clock),
      .ext_joy_data (ext_joy_data),
      .joy_bit      (joy_bit),
      .pad_state    (pad_state)
   );

   nes_joypad_port #(.C_debounce_cycles(DEB), .C_use_external(1'b1)) dut_x (
      .clock        (clock),
      .reset_n      (reset_n),
      .btn_raw      (btn_raw),
      .usb_buttons  (usb_buttons),
      .joy_strobe   (joy_strobe),
      .joy_clock    (joy_clock),
      .ext_joy_data (ext_joy_data),
      .joy_bit      (joy_bit_x),
      .pad_state    (pad_state_x)
   );

   always #5 clock = ~clock;

   // Inputs change and outputs are sampled on the falling edge only
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic strobe_pulse();
      joy_strobe = 1'b1;
      tick(1);
      joy_strobe = 1'b0;
   endtask

   // Return the bit the NES would read, then clock the pad once
   task automatic read_bit(output logic b);
      b = joy_bit;
      joy_clock = 1'b1;
      tick(1);
      joy_clock = 1'b0;
      tick(1);
   endtask

   // Reference: what a pad holding 'pad' returns on read number k (1-based)
   function automatic logic ref_read(input logic [7:0] pad, input int k);
      if (k <= 8) return pad[k-1];
      return 1'b1;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      total++;
      if (joy_bit !== 1'b0) begin
         bad++; $display("FAIL reset_joy_bit got=%b want=0", joy_bit);
      end
      total++;
      if (pad_state !== 8'h00) begin
         bad++; $display("FAIL reset_pad_state got=%h want=00", pad_state);
      end
      total++;
      if (joy_bit_x !== 1'b0) begin
         bad++; $display("FAIL reset_ext_joy_bit got=%b want=0", joy_bit_x);
      end
      tick(6);
      total++;
      if (joy_bit !== 1'b0) begin
         bad++; $display("FAIL reset_hold_joy_bit got=%b want=0", joy_bit);
      end
   endtask

   task automatic test_usb_read();
      logic b;
      usb_buttons = 8'h81;
      tick(5);
      total++;
      if (pad_state !== 8'h81) begin
         bad++; $display("FAIL usb_pad got=%h want=81", pad_state);
      end
      strobe_pulse();
      for (int k = 1; k <= 10; k++) begin
         read_bit(b);
         total++;
         if (b !== ref_read(8'h81, k)) begin
            bad++; $display("FAIL usb_read%0d got=%b want=%b", k, b, ref_read(8'h81, k));
         end
      end
      usb_buttons = 8'h00;
      tick(8);
   endtask

   task automatic test_debounce_toggle();
      logic seen;
      logic stuck;
      stuck = 1'b0;
      for (int c = 0; c < 20; c++) begin
         btn_raw[0] = ((c / 2) % 2 == 0) ? 1'b1 : 1'b0;
         tick(1);
         if (pad_state[0] !== 1'b0) stuck = 1'b1;
      end
      total++;
      if (stuck !== 1'b0) begin
         bad++; $display("FAIL toggle_rejected got=1 want=0");
      end
      btn_raw[0] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 7; c++) begin
         tick(1);
         if (pad_state[0] === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b1) begin
         bad++; $display("FAIL hold_accepted got=%b want=1", pad_state[0]);
      end
      btn_raw[0] = 1'b0;
      tick(10);
      total++;
      if (pad_state !== 8'h00) begin
         bad++; $display("FAIL release_pad got=%h want=00", pad_state);
      end
   endtask

   task automatic test_start();
      logic b;
      btn_raw = 8'h00;
      tick(10);
      total++;
      if (pad_state !== 8'h08) begin
         bad++; $display("FAIL start_pad got=%h want=08", pad_state);
      end
      strobe_pulse();
      for (int k = 1; k <= 8; k++) begin
         read_bit(b);
         total++;
         if (b !== (k == 4)) begin
            bad++; $display("FAIL start_read%0d got=%b want=%b", k, b, (k == 4));
         end
      end
      btn_raw = 8'h08;
      tick(10);
   endtask

   task automatic test_strobe_edge();
      usb_buttons = 8'h02;
      tick(6);
      total++;
      if (pad_state !== 8'h02) begin
         bad++; $display("FAIL coinc_pad got=%h want=02", pad_state);
      end
      joy_clock = 1'b1;
      tick(1);
      joy_strobe = 1'b1;
      joy_clock  = 1'b0;
      tick(1);
      total++;
      if (joy_bit !== 1'b0) begin
         bad++; $display("FAIL coinc_load_wins got=%b want=0", joy_bit);
      end
      joy_strobe = 1'b0;
      tick(1);
      total++;
      if (joy_bit !== 1'b0) begin
         bad++; $display("FAIL coinc_no_shift got=%b want=0", joy_bit);
      end
      joy_clock = 1'b1;
      tick(1);
      joy_clock = 1'b0;
      tick(1);
      total++;
      if (joy_bit !== 1'b1) begin
         bad++; $display("FAIL coinc_next_edge got=%b want=1", joy_bit);
      end
      usb_buttons = 8'h00;
      tick(8);
   endtask

   task automatic test_reset_midread();
      logic       b;
      logic [7:0] w;
      w = 8'($urandom) | 8'h01;
      usb_buttons = w;
      tick(6);
      strobe_pulse();
      for (int k = 1; k <= 3; k++) read_bit(b);
      reset_n = 1'b0;
      tick(1);
      total++;
      if (joy_bit !== 1'b0 || pad_state !== 8'h00) begin
         bad++; $display("FAIL midread_reset got=%b/%h want=0/00", joy_bit, pad_state);
      end
      reset_n = 1'b1;
      tick(10);
      total++;
      if (pad_state !== w) begin
         bad++; $display("FAIL midread_repad got=%h want=%h", pad_state, w);
      end
      strobe_pulse();
      for (int k = 1; k <= 8; k++) begin
         read_bit(b);
         total++;
         if (b !== ref_read(w, k)) begin
            bad++; $display("FAIL midread_read%0d got=%b want=%b", k, b, ref_read(w, k));
         end
      end
      usb_buttons = 8'h00;
      tick(8);
   endtask

   task automatic test_external();
      usb_buttons = 8'($urandom);
      tick(6);
      total++;
      if (joy_bit_x !== 1'b0) begin
         bad++; $display("FAIL ext_idle got=%b want=0", joy_bit_x);
      end
      ext_joy_data = 1'b0;
      tick(1);
      total++;
      if (joy_bit_x !== 1'b0) begin
         bad++; $display("FAIL ext_early got=%b want=0", joy_bit_x);
      end
      tick(1);
      total++;
      if (joy_bit_x !== 1'b1) begin
         bad++; $display("FAIL ext_pressed got=%b want=1", joy_bit_x);
      end
      ext_joy_data = 1'b1;
      tick(2);
      total++;
      if (joy_bit_x !== 1'b0) begin
         bad++; $display("FAIL ext_released got=%b want=0", joy_bit_x);
      end
      usb_buttons = 8'h00;
      tick(8);
   endtask

   task automatic test_random();
      logic       b;
      logic [7:0] btn, usb, want;
      for (int it = 0; it < 6; it++) begin
         btn  = 8'($urandom);
         usb  = 8'($urandom);
         want = (btn ^ 8'h08) | usb;
         btn_raw     = btn;
         usb_buttons = usb;
         tick(12);
         total++;
         if (pad_state !== want) begin
            bad++; $display("FAIL rand_pad%0d got=%h want=%h", it, pad_state, want);
         end
         strobe_pulse();
         for (int k = 1; k <= 10; k++) begin
            read_bit(b);
            total++;
            if (b !== ref_read(want, k)) begin
               bad++; $display("FAIL rand%0d_read%0d got=%b want=%b", it, k, b, ref_read(want, k));
            end
         end
      end
      btn_raw     = 8'h08;
      usb_buttons = 8'h00;
      tick(12);
   endtask

   initial begin
      reset_n      = 1'b0;
      btn_raw      = 8'h08;
      usb_buttons  = 8'h00;
      joy_strobe   = 1'b0;
      joy_clock    = 1'b0;
      ext_joy_data = 1'b1;
      tick(1);
      test_reset();
      test_usb_read();
      test_debounce_toggle();
      test_start();
      test_strobe_edge();
      test_reset_midread();
      test_external();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
